sm_conflict_scheduler: RTL and testbench

SM_CONFLICT_SCHEDULER -- requirements
Module: sm_conflict_scheduler

---
 rtl/sm_conflict_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sm_conflict_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_conflict_scheduler.sv
// rtl/sm_conflict_scheduler.sv - banked scratchpad scheduler serialising lane bank conflicts (optional SM_READ_BROADCAST_EN)
module sm_conflict_scheduler #(
    parameter int LANES    = 16,
    parameter int BANKS    = 16,
    parameter int OFFSET_W = 10,
    parameter int DATA_W   = 32
) (
    input  logic                                           clock,
    input  logic                                           resetn,
    input  logic                                           req_valid,
    output logic                                           req_ready,
    input  logic                                           req_is_store,
    input  logic [LANES-1:0]                               req_lane_mask,
    input  logic [LANES*(OFFSET_W+$clog2(BANKS)+2)-1:0]    req_address,
    input  logic [LANES*(DATA_W/8)-1:0]                    req_byte_mask,
    input  logic [LANES*DATA_W-1:0]                        req_write_data,
    output logic [BANKS-1:0]                               mem_enables,
    output logic                                           mem_is_store,
    output logic [BANKS*OFFSET_W-1:0]                      mem_bank_offsets,
    output logic [BANKS*(DATA_W/8)-1:0]                    mem_byte_mask,
    output logic [BANKS*DATA_W-1:0]                        mem_write_data,
    input  logic [BANKS*DATA_W-1:0]                        mem_read_data,
    output logic                                           resp_valid,
    output logic [LANES-1:0]                               resp_lane_mask,
    output logic [LANES*DATA_W-1:0]                        resp_data
);

    localparam int BANK_W  = $clog2(BANKS);
    localparam int ADDR_W  = OFFSET_W + BANK_W + 2;
    localparam int BYTES   = DATA_W / 8;
    localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state;
    logic [LANES-1:0]    pending;
    logic [LANES-1:0]    pending_next;
    logic [LANES-1:0]    issued_q;
    logic [LANES-1:0]    mask_q;
    logic [LANES-1:0]    grant;
    logic                store_q;
    logic                accept;
    logic                bcast_load;

    logic [BANK_W-1:0]   req_bank [LANES];
    logic [OFFSET_W-1:0] req_off  [LANES];
    logic [LANES*2-1:0]  unused_addr_lsbs;

    logic [BANK_W-1:0]   bank_q  [LANES];
    logic [OFFSET_W-1:0] off_q   [LANES];
    logic [BYTES-1:0]    bmask_q [LANES];
    logic [DATA_W-1:0]   wdata_q [LANES];

    logic [DATA_W-1:0]   rd_bank [BANKS];
    logic [LANE_IW-1:0]  win_idx [BANKS];
    logic [BANKS-1:0]    win_found;

    assign accept    = (state == IDLE) && req_valid;
    assign req_ready = (state == IDLE);

`ifdef SM_READ_BROADCAST_EN
    // Loads may fan one bank read out to every lane sharing the winner's offset.
    assign bcast_load = !store_q;
`else
    assign bcast_load = 1'b0;
`endif

    // Split each lane's byte address into bank select and in-bank offset; the
    // two byte-select bits carry no meaning for word-wide banks.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign req_bank[l] = req_address[l*ADDR_W+2 +: BANK_W];
        assign req_off[l]  = req_address[l*ADDR_W+2+BANK_W +: OFFSET_W];
        assign unused_addr_lsbs[l*2 +: 2] = req_address[l*ADDR_W +: 2];
    end

    // Per bank, the lowest-index pending lane wins; scanning downward lets the
    // last hit be the lowest lane, which keeps same-bank stores in lane order.
    always_comb begin
        win_found = '0;
        for (int b = 0; b < BANKS; b++) begin
            win_idx[b] = '0;
            for (int l = LANES - 1; l >= 0; l--) begin
                if (pending[l] && (bank_q[l] == BANK_W'(b))) begin
                    win_found[b] = 1'b1;
                    win_idx[b]   = LANE_IW'(l);
                end
            end
        end
    end

    // A lane is served when it is its bank's winner, or (broadcast loads only)
    // when it reads the very same entry as that winner.
    always_comb begin
        grant = '0;
        for (int l = 0; l < LANES; l++) begin
            if (pending[l]) begin
                if (win_idx[bank_q[l]] == LANE_IW'(l)) begin
                    grant[l] = 1'b1;
                end else if (bcast_load && (off_q[win_idx[bank_q[l]]] == off_q[l])) begin
                    grant[l] = 1'b1;
                end
            end
        end
        pending_next = pending & ~grant;
    end

    // Bank ports are driven from the winning lane only while issuing.
    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        assign rd_bank[b]     = mem_read_data[b*DATA_W +: DATA_W];
        assign mem_enables[b] = (state == ISSUE) && win_found[b];
        assign mem_bank_offsets[b*OFFSET_W +: OFFSET_W] =
            mem_enables[b] ? off_q[win_idx[b]] : '0;
        assign mem_byte_mask[b*BYTES +: BYTES] =
            mem_enables[b] ? bmask_q[win_idx[b]] : '0;
        assign mem_write_data[b*DATA_W +: DATA_W] =
            mem_enables[b] ? wdata_q[win_idx[b]] : '0;
    end

    assign mem_is_store = (state == ISSUE) && store_q;

    // Control FSM: accept, issue until no lane is pending, one drain cycle for
    // the last read, then a single-cycle response.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            pending        <= '0;
            issued_q       <= '0;
            mask_q         <= '0;
            store_q        <= 1'b0;
            resp_valid     <= 1'b0;
            resp_lane_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid     <= 1'b0;
                    resp_lane_mask <= '0;
                    issued_q       <= '0;
                    if (req_valid) begin
                        store_q <= req_is_store;
                        mask_q  <= req_lane_mask;
                        pending <= req_lane_mask;
                        if (req_lane_mask == '0) begin
                            state          <= DONE;
                            resp_valid     <= 1'b1;
                            resp_lane_mask <= '0;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    pending  <= pending_next;
                    issued_q <= grant;
                    if (pending_next == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    issued_q       <= '0;
                    state          <= DONE;
                    resp_valid     <= 1'b1;
                    resp_lane_mask <= mask_q;
                end
                DONE: begin
                    resp_valid     <= 1'b0;
                    resp_lane_mask <= '0;
                    state          <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Request payload is held for the whole busy period.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < LANES; l++) begin
                bank_q[l]  <= '0;
                off_q[l]   <= '0;
                bmask_q[l] <= '0;
                wdata_q[l] <= '0;
            end
        end else if (accept) begin
            for (int l = 0; l < LANES; l++) begin
                bank_q[l]  <= req_bank[l];
                off_q[l]   <= req_off[l];
                bmask_q[l] <= req_byte_mask[l*BYTES +: BYTES];
                wdata_q[l] <= req_write_data[l*DATA_W +: DATA_W];
            end
        end
    end

    // Bank read data lands one cycle after issue; route it to the lanes that
    // were served in that issue cycle. Stores leave their lanes at zero.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            resp_data <= '0;
        end else if (accept) begin
            resp_data <= '0;
        end else if (((state == ISSUE) || (state == DRAIN)) && !store_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (issued_q[l]) begin
                    resp_data[l*DATA_W +: DATA_W] <= rd_bank[bank_q[l]];
                end
            end
        end
    end

endmodule

// File: tb/tb_sm_conflict_scheduler.sv
// tb/tb_sm_conflict_scheduler.sv - directed self-checking bench for sm_conflict_scheduler
module tb_sm_conflict_scheduler;

    localparam int L  = 16;
    localparam int B  = 16;
    localparam int OW = 10;
    localparam int DW = 32;
    localparam int AW = OW + 4 + 2;

    logic              clock;
    logic              resetn;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [L-1:0]      req_lane_mask;
    logic [L*AW-1:0]   req_address;
    logic [L*4-1:0]    req_byte_mask;
    logic [L*DW-1:0]   req_write_data;
    logic [B-1:0]      mem_enables;
    logic              mem_is_store;
    logic [B*OW-1:0]   mem_bank_offsets;
    logic [B*4-1:0]    mem_byte_mask;
    logic [B*DW-1:0]   mem_write_data;
    logic [B*DW-1:0]   mem_read_data;
    logic              resp_valid;
    logic [L-1:0]      resp_lane_mask;
    logic [L*DW-1:0]   resp_data;

    sm_conflict_scheduler dut (
        .clock            (clock),
        .resetn           (resetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_lane_mask    (req_lane_mask),
        .req_address      (req_address),
        .req_byte_mask    (req_byte_mask),
        .req_write_data   (req_write_data),
        .mem_enables      (mem_enables),
        .mem_is_store     (mem_is_store),
        .mem_bank_offsets (mem_bank_offsets),
        .mem_byte_mask    (mem_byte_mask),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data),
        .resp_valid       (resp_valid),
        .resp_lane_mask   (resp_lane_mask),
        .resp_data        (resp_data)
    );

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [B][1024];
    logic [31:0] wr_log [$];

    logic [AW-1:0]  lane_addr  [L];
    logic [DW-1:0]  lane_wdata [L];
    logic [3:0]     lane_bm    [L];

    int            r_lat;
    int            r_issues;
    logic          r_seen;
    logic          r_store_seen;
    logic [L-1:0]  r_mask;
    logic [L*DW-1:0] r_data;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] pat(input int bank, input int off);
        return 32'hC000_0000 | (32'(bank) << 16) | 32'(off);
    endfunction

    // Bank memory model: one-cycle read latency, byte-masked writes.
    always @(posedge clock) begin
        for (int b = 0; b < B; b++) begin
            if (mem_enables[b]) begin
                if (mem_is_store) begin
                    for (int k = 0; k < 4; k++) begin
                        if (mem_byte_mask[b*4 + k])
                            mem[b][mem_bank_offsets[b*OW +: OW]][k*8 +: 8] = mem_write_data[b*DW + k*8 +: 8];
                    end
                    if (b == 0) wr_log.push_back(mem_write_data[31:0]);
                end else begin
                    mem_read_data[b*DW +: DW] <= mem[b][mem_bank_offsets[b*OW +: OW]];
                end
            end
        end
    end

    task automatic clear_lanes();
        for (int i = 0; i < L; i++) begin
            lane_addr[i]  = '0;
            lane_wdata[i] = '0;
            lane_bm[i]    = '0;
        end
    endtask

    task automatic run_req(input logic st, input logic [L-1:0] m);
        @(negedge clock);
        req_is_store  = st;
        req_lane_mask = m;
        for (int i = 0; i < L; i++) begin
            req_address[i*AW +: AW]    = lane_addr[i];
            req_write_data[i*DW +: DW] = lane_wdata[i];
            req_byte_mask[i*4 +: 4]    = lane_bm[i];
        end
        req_valid = 1'b1;
        @(negedge clock);
        req_valid    = 1'b0;
        r_lat        = 0;
        r_issues     = 0;
        r_seen       = 1'b0;
        r_store_seen = 1'b0;
        r_mask       = '0;
        r_data       = '0;
        for (int c = 0; c < 64 && !r_seen; c++) begin
            r_lat++;
            if (mem_enables != '0) r_issues++;
            if (mem_is_store) r_store_seen = 1'b1;
            if (resp_valid) begin
                r_seen = 1'b1;
                r_mask = resp_lane_mask;
                r_data = resp_data;
            end else begin
                @(negedge clock);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b expected 1", req_ready); else passed++;
        total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b expected 0", resp_valid); else passed++;
        total++; if (mem_enables !== '0) $display("FAIL reset_enables got %h expected 0", mem_enables); else passed++;
        total++; if (resp_lane_mask !== '0) $display("FAIL reset_resp_mask got %h expected 0", resp_lane_mask); else passed++;
        total++; if (resp_data !== '0) $display("FAIL reset_resp_data got %h expected 0", resp_data); else passed++;
        resetn = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_distinct_banks();
        logic [L*DW-1:0] exp;
        clear_lanes();
        for (int i = 0; i < L; i++) lane_addr[i] = AW'(4 * i);
        for (int i = 0; i < L; i++) exp[i*DW +: DW] = pat(i, 0);
        run_req(1'b0, 16'hFFFF);
        total++; if (r_seen !== 1'b1) $display("FAIL distinct_timeout got %b expected 1", r_seen); else passed++;
        total++; if (r_lat != 3) $display("FAIL distinct_latency got %0d expected 3", r_lat); else passed++;
        total++; if (r_issues != 1) $display("FAIL distinct_issue_cycles got %0d expected 1", r_issues); else passed++;
        total++; if (r_mask !== 16'hFFFF) $display("FAIL distinct_mask got %h expected ffff", r_mask); else passed++;
        total++; if (r_data !== exp) $display("FAIL distinct_data got %h expected %h", r_data, exp); else passed++;
        @(negedge clock);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL distinct_resp_one_cycle got valid=%b ready=%b expected valid=0 ready=1", resp_valid, req_ready);
        else passed++;
    endtask

    task automatic test_conflict_load();
        logic [L*DW-1:0] exp;
        int exp_lat;
        int exp_iss;
`ifdef SM_READ_BROADCAST_EN
        exp_lat = 3;
        exp_iss = 1;
`else
        exp_lat = 6;
        exp_iss = 4;
`endif
        clear_lanes();
        exp = '0;
        for (int i = 0; i < 4; i++) begin
            lane_addr[i] = 16'h0040;
            exp[i*DW +: DW] = pat(0, 1);
        end
        run_req(1'b0, 16'h000F);
        total++; if (r_seen !== 1'b1) $display("FAIL conflict_timeout got %b expected 1", r_seen); else passed++;
        total++; if (r_lat != exp_lat) $display("FAIL conflict_latency got %0d expected %0d", r_lat, exp_lat); else passed++;
        total++; if (r_issues != exp_iss) $display("FAIL conflict_issue_cycles got %0d expected %0d", r_issues, exp_iss); else passed++;
        total++; if (r_mask !== 16'h000F) $display("FAIL conflict_mask got %h expected 000f", r_mask); else passed++;
        total++; if (r_data !== exp) $display("FAIL conflict_data got %h expected %h", r_data, exp); else passed++;
    endtask

    task automatic test_store_order();
        clear_lanes();
        lane_addr[0] = 16'h0080; lane_wdata[0] = 32'hA; lane_bm[0] = 4'hF;
        lane_addr[5] = 16'h0080; lane_wdata[5] = 32'hB; lane_bm[5] = 4'hF;
        wr_log.delete();
        run_req(1'b1, 16'h0021);
        total++; if (r_issues != 2) $display("FAIL store_issue_cycles got %0d expected 2", r_issues); else passed++;
        total++; if (r_lat != 4) $display("FAIL store_latency got %0d expected 4", r_lat); else passed++;
        total++; if (r_store_seen !== 1'b1) $display("FAIL store_mem_is_store got %b expected 1", r_store_seen); else passed++;
        total++; if (r_data !== '0) $display("FAIL store_resp_data got %h expected 0", r_data); else passed++;
        total++; if (wr_log.size() != 2) $display("FAIL store_write_count got %0d expected 2", wr_log.size());
        else begin
            passed++;
            total++; if (wr_log[0] !== 32'hA) $display("FAIL store_first_write got %h expected a", wr_log[0]); else passed++;
            total++; if (wr_log[1] !== 32'hB) $display("FAIL store_second_write got %h expected b", wr_log[1]); else passed++;
        end
        total++; if (mem_is_store !== 1'b0) $display("FAIL store_flag_idle got %b expected 0", mem_is_store); else passed++;
        clear_lanes();
        lane_addr[3] = 16'h0080;
        run_req(1'b0, 16'h0008);
        total++; if (r_data[3*DW +: DW] !== 32'hB) $display("FAIL store_readback got %h expected b", r_data[3*DW +: DW]); else passed++;
        total++; if (r_lat != 3) $display("FAIL store_readback_latency got %0d expected 3", r_lat); else passed++;
    endtask

    task automatic test_zero_mask();
        clear_lanes();
        run_req(1'b0, 16'h0000);
        total++; if (r_seen !== 1'b1) $display("FAIL zero_timeout got %b expected 1", r_seen); else passed++;
        total++; if (r_lat != 1) $display("FAIL zero_latency got %0d expected 1", r_lat); else passed++;
        total++; if (r_issues != 0) $display("FAIL zero_enables got %0d expected 0", r_issues); else passed++;
        total++; if (r_mask !== '0) $display("FAIL zero_mask got %h expected 0", r_mask); else passed++;
    endtask

    task automatic test_back_to_back();
        int   lat;
        logic seen;
        logic busy_ready;
        logic [L*DW-1:0] exp;
        clear_lanes();
        exp = '0;
        exp[0*DW +: DW] = pat(0, 0);
        exp[1*DW +: DW] = pat(0, 1);
        @(negedge clock);
        req_is_store  = 1'b0;
        req_lane_mask = 16'h0003;
        req_address   = '0;
        req_address[1*AW +: AW] = 16'h0040;
        req_valid = 1'b1;
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_initial_ready got %b expected 1", req_ready); else passed++;
        lat = 0;
        seen = 1'b0;
        busy_ready = 1'b0;
        for (int c = 0; c < 32 && !seen; c++) begin
            @(negedge clock);
            lat++;
            if (resp_valid) seen = 1'b1;
            else if (req_ready) busy_ready = 1'b1;
        end
        total++; if (lat != 4 || !seen) $display("FAIL b2b_latency got %0d expected 4", lat); else passed++;
        total++; if (busy_ready !== 1'b0) $display("FAIL b2b_ready_while_busy got %b expected 0", busy_ready); else passed++;
        total++; if (resp_data !== exp) $display("FAIL b2b_data got %h expected %h", resp_data, exp); else passed++;
        req_lane_mask = 16'h0000;
        @(negedge clock);
        total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready_after_resp got %b expected 1", req_ready); else passed++;
        @(negedge clock);
        req_valid = 1'b0;
        total++; if (resp_valid !== 1'b1 || resp_lane_mask !== '0)
            $display("FAIL b2b_second_resp got valid=%b mask=%h expected valid=1 mask=0", resp_valid, resp_lane_mask);
        else passed++;
        @(negedge clock);
        total++; if (resp_valid !== 1'b0) $display("FAIL b2b_no_third got %b expected 0", resp_valid); else passed++;
    endtask

    task automatic test_reset_mid_request();
        logic stray;
        clear_lanes();
        @(negedge clock);
        req_is_store  = 1'b0;
        req_lane_mask = 16'h0007;
        req_address   = '0;
        req_address[1*AW +: AW] = 16'h0040;
        req_address[2*AW +: AW] = 16'h0080;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        total++; if (mem_enables !== 16'h0001) $display("FAIL midrst_first_issue got %h expected 0001", mem_enables); else passed++;
        @(negedge clock);
        total++; if (mem_enables !== 16'h0001) $display("FAIL midrst_second_issue got %h expected 0001", mem_enables); else passed++;
        resetn = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1) $display("FAIL midrst_ready got %b expected 1", req_ready); else passed++;
        total++; if (mem_enables !== '0) $display("FAIL midrst_enables got %h expected 0", mem_enables); else passed++;
        @(negedge clock);
        resetn = 1'b1;
        stray = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (resp_valid || mem_enables != '0) stray = 1'b1;
        end
        total++; if (stray !== 1'b0) $display("FAIL midrst_abandoned got %b expected 0", stray); else passed++;
    endtask

    initial begin
        resetn         = 1'b0;
        req_valid      = 1'b0;
        req_is_store   = 1'b0;
        req_lane_mask  = '0;
        req_address    = '0;
        req_byte_mask  = '0;
        req_write_data = '0;
        mem_read_data  = '0;
        for (int b = 0; b < B; b++)
            for (int o = 0; o < 1024; o++)
                mem[b][o] = pat(b, o);
        test_reset();
        test_distinct_banks();
        test_conflict_load();
        test_store_order();
        test_zero_mask();
        test_back_to_back();
        test_reset_mid_request();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
